balun_stream: RTL and testbench

- Multi-channel streaming digital balun: converts single-ended signed samples into a balanced pair, out_p = +x·T1 and out_n = −x·T2.
- T1/T2 are programmable per channel, generalising the fixed-ratio ideal balun to N channels, configurable width and ratio.
- Sits between the sample source and differential DAC/model blocks; valid/ready on both sides; 2-stage pipeline with full backpressure.

---
 rtl/balun_stream.sv | 126 ++++++++++++
 tb/tb_balun_stream.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/balun_stream.sv
// balun_stream: multi-channel streaming balun, out_p = +x*T1, out_n = -x*T2, per-channel Q1.(COEF_W-1) coefficients.
// Define BALUN_SATCNT_EN to add the sat_cnt output counting clipped output pairs.
module balun_stream #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 8,
  parameter int CHANNELS = 2,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]          in_chan,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_chan,
  input  logic [COEF_W-1:0]        cfg_t1,
  input  logic [COEF_W-1:0]        cfg_t2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_p,
  output logic signed [DATA_W-1:0] out_n,
  output logic [CH_W-1:0]          out_chan,
`ifdef BALUN_SATCNT_EN
  output logic [15:0]              sat_cnt,
`endif
  output logic                     err
);
  localparam int PW = DATA_W + COEF_W + 1;
  localparam logic [COEF_W-1:0] T_RST = COEF_W'(1) << (COEF_W - 2);
  localparam logic signed [PW:0] RND = (PW + 1)'(1) << (COEF_W - 2);
  localparam logic signed [PW:0] SMAX = (PW + 1)'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [PW:0] SMIN = -SMAX - (PW + 1)'(1);
  logic [COEF_W-1:0] t1_q [CHANNELS];
  logic [COEF_W-1:0] t2_q [CHANNELS];
  logic [COEF_W-1:0] t1_sel, t2_sel;
  logic stall, in_ok;
  logic v1_q, v2_q, vo_q, err_q;
  logic signed [DATA_W-1:0] x1_q, op_q, on_q;
  logic [COEF_W-1:0] ta1_q, tb1_q;
  logic [CH_W-1:0] ch1_q, ch2_q, cho_q;
  logic signed [PW-1:0] p2_q, n2_q, p_d, n_d;
  function automatic logic signed [PW:0] rs(input logic signed [PW-1:0] v);
    return ((PW + 1)'(v) + RND) >>> (COEF_W - 1);
  endfunction
  function automatic logic clip(input logic signed [PW-1:0] v);
    return rs(v) > SMAX || rs(v) < SMIN;
  endfunction
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [PW-1:0] v);
    return rs(v) > SMAX ? DATA_W'(SMAX) : rs(v) < SMIN ? DATA_W'(SMIN) : DATA_W'(rs(v));
  endfunction
  assign stall     = vo_q && !out_ready;
  assign in_ready  = !stall;
  assign in_ok     = int'(in_chan) < CHANNELS;
  assign out_valid = vo_q;
  assign out_p     = op_q;
  assign out_n     = on_q;
  assign out_chan  = cho_q;
  assign err       = err_q;
  // widened products keep -x exact for the most negative sample
  assign p_d = PW'(x1_q) * PW'($signed({1'b0, ta1_q}));
  assign n_d = -(PW'(x1_q) * PW'($signed({1'b0, tb1_q})));
  always_comb begin
    t1_sel = '0;
    t2_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      t1_sel = (in_chan == CH_W'(i)) ? t1_q[i] : t1_sel;
      t2_sel = (in_chan == CH_W'(i)) ? t2_q[i] : t2_sel;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      vo_q  <= 1'b0;
      x1_q  <= '0;
      ta1_q <= '0;
      tb1_q <= '0;
      ch1_q <= '0;
      p2_q  <= '0;
      n2_q  <= '0;
      ch2_q <= '0;
      op_q  <= '0;
      on_q  <= '0;
      cho_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        t1_q[i] <= T_RST;
        t2_q[i] <= T_RST;
      end
    end else begin
      if (!stall) begin
        v1_q  <= in_valid && in_ok;
        x1_q  <= in_data;
        ta1_q <= t1_sel;
        tb1_q <= t2_sel;
        ch1_q <= in_chan;
        v2_q  <= v1_q;
        p2_q  <= p_d;
        n2_q  <= n_d;
        ch2_q <= ch1_q;
        vo_q  <= v2_q;
        if (v2_q) begin
          op_q  <= sat(p2_q);
          on_q  <= sat(n2_q);
          cho_q <= ch2_q;
        end
      end
      err_q <= err_q || (in_valid && !stall && !in_ok);
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_we && cfg_chan == CH_W'(i)) begin
          t1_q[i] <= cfg_t1;
          t2_q[i] <= cfg_t2;
        end
      end
    end
  end
`ifdef BALUN_SATCNT_EN
  logic [15:0] sat_q;
  assign sat_cnt = sat_q;
  always_ff @(posedge clk) begin
    if (!rst_n) sat_q <= '0;
    else if (!stall && v2_q && (clip(p2_q) || clip(n2_q)) && sat_q != 16'hFFFF) sat_q <= sat_q + 16'd1;
  end
`endif
endmodule

// File: tb/tb_balun_stream.sv
// tb_balun_stream: directed self-checking bench for balun_stream (3 channels so channel 3 is out of range).
module tb_balun_stream;
  logic clk, rst_n, in_valid, in_ready, cfg_we, out_valid, out_ready, err;
  logic signed [15:0] in_data, out_p, out_n;
  logic [1:0] in_chan, cfg_chan, out_chan;
  logic [7:0] cfg_t1, cfg_t2;
`ifdef BALUN_SATCNT_EN
  logic [15:0] sat_cnt;
`endif
  int tests = 0;
  int fails = 0;
  balun_stream #(.DATA_W(16), .COEF_W(8), .CHANNELS(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_chan(in_chan), .cfg_we(cfg_we), .cfg_chan(cfg_chan),
    .cfg_t1(cfg_t1), .cfg_t2(cfg_t2), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_n(out_n), .out_chan(out_chan),
`ifdef BALUN_SATCNT_EN
    .sat_cnt(sat_cnt),
`endif
    .err(err)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int x, input int ch);
    in_valid = 1'b1;
    in_data  = 16'(x);
    in_chan  = 2'(ch);
    step();
    in_valid = 1'b0;
  endtask
  task automatic cfg(input int ch, input int t1, input int t2);
    cfg_we   = 1'b1;
    cfg_chan = 2'(ch);
    cfg_t1   = 8'(t1);
    cfg_t2   = 8'(t2);
    step();
    cfg_we   = 1'b0;
  endtask
  task automatic one(input string tag, input int x, input int ch, input int ep, input int en);
    send(x, ch);
    chk({tag, "_v_k"}, int'(out_valid), 0);
    step();
    chk({tag, "_v_k1"}, int'(out_valid), 0);
    step();
    chk({tag, "_v_k2"}, int'(out_valid), 1);
    chk({tag, "_p"}, int'(out_p), ep);
    chk({tag, "_n"}, int'(out_n), en);
    chk({tag, "_chan"}, int'(out_chan), ch);
    step();
    chk({tag, "_v_after"}, int'(out_valid), 0);
  endtask
  initial begin
    int xs [5] = '{10, 20, 30, 40, 50};
    int ii = 0;
    int oi = 0;
    int scnt = 0;
    bit seen = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_chan = '0;
    cfg_we = 1'b0;
    cfg_chan = '0;
    cfg_t1 = '0;
    cfg_t2 = '0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_p", int'(out_p), 0);
    chk("rst_n_leg", int'(out_n), 0);
    chk("rst_chan", int'(out_chan), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    chk("rst_in_ready", int'(in_ready), 1);
    one("dflt", 1000, 0, 500, -500);
    one("rnd_pos", 3, 0, 2, -1);
    one("rnd_neg", -3, 0, -1, 2);
    cfg(1, 255, 128);
    one("sat_hi", 20000, 1, 32767, -20000);
    one("sat_min", -32768, 1, -32768, 32767);
`ifdef BALUN_SATCNT_EN
    chk("sat_cnt", int'(sat_cnt), 2);
`endif
    cfg_we = 1'b1;
    cfg_chan = 2'd0;
    cfg_t1 = 8'd128;
    cfg_t2 = 8'd64;
    in_valid = 1'b1;
    in_data = 16'sd100;
    in_chan = 2'd0;
    step();
    cfg_we = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    chk("race_old_p", int'(out_p), 50);
    chk("race_old_n", int'(out_n), -50);
    step();
    chk("race_new_p", int'(out_p), 100);
    chk("race_new_n", int'(out_n), -50);
    step();
    for (int c = 0; c < 40 && oi < 5; c++) begin
      if (out_valid && !seen) seen = 1;
      out_ready = !(seen && scnt < 4);
      in_valid = ii < 5;
      in_data = 16'(xs[ii < 5 ? ii : 4]);
      in_chan = 2'd0;
      @(negedge clk);
      if (out_valid && !out_ready) chk("bp_in_ready", int'(in_ready), 0);
      if (out_valid) begin
        chk("bp_p", int'(out_p), xs[oi]);
        chk("bp_n", int'(out_n), -xs[oi] / 2);
      end
      if (out_valid && out_ready) oi++;
      if (in_valid && in_ready) ii++;
      if (seen && scnt < 4) scnt++;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_delivered", oi, 5);
    step();
    step();
    chk("bp_no_dup", int'(out_valid), 0);
    cfg(3, 1, 1);
    one("ch2_dflt", 1000, 2, 500, -500);
    one("ch0_kept", 100, 0, 100, -50);
    one("ch1_kept", 200, 1, 398, -200);
    in_valid = 1'b1;
    in_data = 16'sd500;
    in_chan = 2'd3;
    chk("bad_in_ready", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("bad_no_out", int'(out_valid), 0);
      step();
    end
    chk("bad_err", int'(err), 1);
    step();
    chk("bad_err_sticky", int'(err), 1);
`ifdef BALUN_SATCNT_EN
    chk("sat_cnt_kept", int'(sat_cnt), 2);
`endif
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("err_cleared", int'(err), 0);
    chk("rst2_valid", int'(out_valid), 0);
    one("rst2_dflt", 1000, 0, 500, -500);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
